// File: rtl/gon_tag_sequencer_pkg.sv
// ============================================================================
// Module : gon_tag_sequencer_pkg
// Brief  : Shared types and default widths for the GON tag sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package gon_tag_sequencer_pkg;

  localparam int c_data_width_def  = 64;
  localparam int c_tag_width_def   = 4;
  localparam int c_len_width_def   = 8;
  localparam int c_max_entries_def = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    FIN  = 2'd3
  } gon_seq_state_t;

  typedef struct packed {
    logic [c_tag_width_def-1:0] row_tag;
    logic [c_tag_width_def-1:0] col_tag;
    logic [c_len_width_def-1:0] len;
  } gon_sched_entry_t;

endpackage

`default_nettype wire

// File: rtl/gon_tag_sequencer_if.sv
// ============================================================================
// Module : gon_tag_sequencer_if
// Brief  : Upstream source handshake plus GON bus, seen from both sides.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface gon_tag_sequencer_if
  import gon_tag_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = c_data_width_def,
  parameter int TAG_WIDTH  = c_tag_width_def
);

  logic [DATA_WIDTH-1:0] src_data;
  logic                  src_valid;
  logic                  src_ready;
  logic [TAG_WIDTH-1:0]  row_tag;
  logic [TAG_WIDTH-1:0]  col_tag;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  enable_out;
  logic                  ready_in;

  modport master (
    input  src_data, src_valid, ready_in,
    output src_ready, row_tag, col_tag, data_out, enable_out
  );

  modport slave (
    output src_data, src_valid, ready_in,
    input  src_ready, row_tag, col_tag, data_out, enable_out
  );

endinterface

`default_nettype wire

// File: rtl/gon_tag_sequencer_sched_table.sv
// ============================================================================
// Module : gon_tag_sequencer_sched_table
// Brief  : Schedule register file, one sync write port, one async read port.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module gon_tag_sequencer_sched_table
  import gon_tag_sequencer_pkg::*;
#(
  parameter int  MAX_ENTRIES = c_max_entries_def,
  parameter type ENTRY_T     = gon_sched_entry_t,
  localparam int IDX_W       = $clog2(MAX_ENTRIES)
) (
  input  wire logic             clk,
  input  wire logic             i_we,
  input  wire logic [IDX_W-1:0] i_waddr,
  input  wire ENTRY_T           i_wdata,
  input  wire logic [IDX_W-1:0] i_raddr,
  output      ENTRY_T           o_rdata
);

  // Contents are deliberately not reset; software reprograms before each run.
  ENTRY_T r_mem [MAX_ENTRIES];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/gon_tag_sequencer.sv
// ============================================================================
// Module : gon_tag_sequencer
// Brief  : Walks the schedule table and streams tagged beats onto the GON.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module gon_tag_sequencer
  import gon_tag_sequencer_pkg::*;
#(
  parameter int  DATA_WIDTH  = c_data_width_def,
  parameter int  TAG_WIDTH   = c_tag_width_def,
  parameter int  LEN_WIDTH   = c_len_width_def,
  parameter int  MAX_ENTRIES = c_max_entries_def,
  localparam int IDX_W       = $clog2(MAX_ENTRIES)
) (
  input  wire logic                 clk,
  input  wire logic                 reset,
  input  wire logic                 cfg_we,
  input  wire logic [IDX_W-1:0]     cfg_addr,
  input  wire logic [TAG_WIDTH-1:0] cfg_row_tag,
  input  wire logic [TAG_WIDTH-1:0] cfg_col_tag,
  input  wire logic [LEN_WIDTH-1:0] cfg_len,
  input  wire logic                 start,
  input  wire logic [IDX_W:0]       num_entries,
  output      logic                 busy,
  output      logic                 done,
  gon_tag_sequencer_if.master       bus
);

  typedef struct packed {
    logic [TAG_WIDTH-1:0] row_tag;
    logic [TAG_WIDTH-1:0] col_tag;
    logic [LEN_WIDTH-1:0] len;
  } entry_t;

  localparam logic [IDX_W:0] c_max_entries = (IDX_W+1)'(MAX_ENTRIES);

  gon_seq_state_t        r_state;
  logic [IDX_W:0]        r_idx;
  logic [IDX_W:0]        r_num;
  logic [LEN_WIDTH-1:0]  r_issue_cnt;
  logic [LEN_WIDTH-1:0]  r_accept_cnt;
  logic [TAG_WIDTH-1:0]  r_row_tag;
  logic [TAG_WIDTH-1:0]  r_col_tag;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_enable;
  logic                  r_busy;
  logic                  r_done;

  entry_t                w_wr_entry;
  entry_t                w_rd_entry;
  logic [IDX_W:0]        w_idx_next;
  logic [IDX_W:0]        w_num_clamped;
  logic                  w_last_entry;
  logic                  w_src_ready;
  logic                  w_pop;
  logic                  w_xfer;

  assign w_wr_entry = '{row_tag: cfg_row_tag, col_tag: cfg_col_tag, len: cfg_len};

  gon_tag_sequencer_sched_table #(
    .MAX_ENTRIES (MAX_ENTRIES),
    .ENTRY_T     (entry_t)
  ) u_table (
    .clk     (clk),
    .i_we    (cfg_we && (r_state == IDLE)),
    .i_waddr (cfg_addr),
    .i_wdata (w_wr_entry),
    .i_raddr (r_idx[IDX_W-1:0]),
    .o_rdata (w_rd_entry)
  );

  assign w_idx_next    = r_idx + 1'b1;
  assign w_last_entry  = (w_idx_next >= r_num);
  assign w_num_clamped = (num_entries > c_max_entries) ? c_max_entries : num_entries;

  // Pop only when the output register is free or draining this same cycle.
  assign w_src_ready = (r_state == SEND) && (r_issue_cnt != '0) && (!r_enable || bus.ready_in);
  assign w_pop       = w_src_ready && bus.src_valid;
  assign w_xfer      = r_enable && bus.ready_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_num        <= '0;
      r_issue_cnt  <= '0;
      r_accept_cnt <= '0;
      r_row_tag    <= '1;
      r_col_tag    <= '1;
      r_data       <= '0;
      r_enable     <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_num   <= w_num_clamped;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= (w_num_clamped == '0) ? FIN : LOAD;
          end
        end
        LOAD: begin
          r_row_tag    <= w_rd_entry.row_tag;
          r_col_tag    <= w_rd_entry.col_tag;
          r_issue_cnt  <= w_rd_entry.len;
          r_accept_cnt <= w_rd_entry.len;
          if (w_rd_entry.len == '0) begin
            r_idx   <= w_idx_next;
            r_state <= w_last_entry ? FIN : LOAD;
          end else begin
            r_state <= SEND;
          end
        end
        SEND: begin
          if (w_pop) begin
            r_data      <= bus.src_data;
            r_enable    <= 1'b1;
            r_issue_cnt <= r_issue_cnt - 1'b1;
          end else if (w_xfer) begin
            r_enable <= 1'b0;
          end
          if (w_xfer) begin
            r_accept_cnt <= r_accept_cnt - 1'b1;
            if (r_accept_cnt == LEN_WIDTH'(1)) begin
              r_idx   <= w_idx_next;
              r_state <= w_last_entry ? FIN : LOAD;
            end
          end
        end
        FIN: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.src_ready  = w_src_ready;
  assign bus.row_tag    = r_row_tag;
  assign bus.col_tag    = r_col_tag;
  assign bus.data_out   = r_data;
  assign bus.enable_out = r_enable;
  assign busy           = r_busy;
  assign done           = r_done;

endmodule

`default_nettype wire
